// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory-access pipeline stage sitting between EX and WB.
//
// Holds one instruction from EX. Loads wait here until their read response
// arrives on the data-memory response channel. A response that arrives while
// WB is stalled is parked in a one-entry buffer. Responses owed to flushed
// loads are counted and silently dropped when they arrive. Load data is
// aligned by the low address bits and then sign- or zero-extended.
//
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   ex_to_mem_valid        EX presents an instruction
//   mem_allowin            MEM can take an instruction from EX this cycle
//   ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result,
//   ex_ld_req, ex_ld_size, ex_ld_unsigned, ex_res_sel, ex_div_result
//                          payload captured from EX
//   mul_result             multiplier product for the instruction held in MEM
//   data_rsp_valid/rdata   in-order read response, one-cycle pulse
//   flush                  kill the MEM instruction and block acceptance
//   wb_allowin             WB can accept
//   mem_to_wb_*            result toward WB
//   mem_fwd_*              forwarding bus; pending = load still waiting
//   rsp_err                sticky: a response arrived with nobody to own it
module mem_stage_hs #(
    parameter int DATA_W = 32,
    parameter int DCNT_W = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ex_to_mem_valid,
    output logic                  mem_allowin,
    input  logic [31:0]           ex_pc,
    input  logic                  ex_rf_we,
    input  logic [4:0]            ex_rf_waddr,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic                  ex_ld_req,
    input  logic [1:0]            ex_ld_size,
    input  logic                  ex_ld_unsigned,
    input  logic [1:0]            ex_res_sel,
    input  logic [DATA_W-1:0]     ex_div_result,
    input  logic [2*DATA_W-1:0]   mul_result,
    input  logic                  data_rsp_valid,
    input  logic [DATA_W-1:0]     data_rsp_rdata,
    input  logic                  flush,
    input  logic                  wb_allowin,
    output logic                  mem_to_wb_valid,
    output logic [31:0]           mem_to_wb_pc,
    output logic                  mem_to_wb_rf_we,
    output logic [4:0]            mem_to_wb_rf_waddr,
    output logic [DATA_W-1:0]     mem_to_wb_rf_wdata,
    output logic                  mem_fwd_we,
    output logic [4:0]            mem_fwd_waddr,
    output logic [DATA_W-1:0]     mem_fwd_wdata,
    output logic                  mem_fwd_pending,
    output logic                  rsp_err
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam logic [DCNT_W-1:0] DCNT_MAX = '1;

    // Shift the word right by the byte offset, keep the low 8/16/32/64 bits
    // and extend. A 32-bit datapath has no dword, so size 3 reads a word.
    function automatic logic [DATA_W-1:0] ld_align(
        input logic [DATA_W-1:0] d,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        logic [1:0]        sz;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] w_s;
        sh  = d >> {off, 3'b000};
        sz  = (DATA_W == 32 && size == 2'd3) ? 2'd2 : size;
        b_s = sh[7:0];
        h_s = sh[15:0];
        w_s = sh[31:0];
        r   = sh;
        case (sz)
            2'd0: begin
                if (uns) r = DATA_W'(sh[7:0]);
                else     r = DATA_W'(b_s);
            end
            2'd1: begin
                if (uns) r = DATA_W'(sh[15:0]);
                else     r = DATA_W'(h_s);
            end
            2'd2: begin
                if (uns) r = DATA_W'(sh[31:0]);
                else     r = DATA_W'(w_s);
            end
            default: r = sh;
        endcase
        return r;
    endfunction

    logic                 mem_valid;
    logic [31:0]          pc_p0;
    logic                 rf_we_p0;
    logic [4:0]           rf_waddr_p0;
    logic [DATA_W-1:0]    alu_p0;
    logic                 ld_req_p0;
    logic [1:0]           ld_size_p0;
    logic                 ld_uns_p0;
    logic [1:0]           res_sel_p0;
    logic [DATA_W-1:0]    div_p0;
    logic                 rbuf_valid;
    logic [DATA_W-1:0]    rbuf;
    logic [DCNT_W-1:0]    dcnt;

    logic                 take_rsp;
    logic                 mem_ready_go;
    logic                 ld_wait;
    logic                 rsp_capture;
    logic                 rsp_unexp;
    logic                 mem_leave;
    logic                 accept;
    logic                 dcnt_inc;
    logic                 dcnt_dec;
    logic                 dcnt_ovf;
    logic [DATA_W-1:0]    ld_data;
    logic [DATA_W-1:0]    ld_result;
    logic [DATA_W-1:0]    wdata;

    assign take_rsp     = data_rsp_valid & (dcnt == '0);
    assign mem_ready_go = ~ld_req_p0 | rbuf_valid | take_rsp;
    assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);
    assign accept       = ex_to_mem_valid & mem_allowin & ~flush;
    assign mem_leave    = mem_valid & mem_ready_go & wb_allowin & ~flush;

    // A load still owed its response; an arriving response belongs to it,
    // even if it is being flushed this cycle (then it is simply consumed).
    assign ld_wait      = mem_valid & ld_req_p0 & ~rbuf_valid;
    assign rsp_capture  = take_rsp & ld_wait & ~wb_allowin & ~flush;
    assign rsp_unexp    = take_rsp & ~ld_wait;

    assign dcnt_inc     = flush & ld_wait & ~take_rsp;
    assign dcnt_dec     = data_rsp_valid & (dcnt != '0);
    assign dcnt_ovf     = dcnt_inc & ~dcnt_dec & (dcnt == DCNT_MAX);

    assign ld_data      = rbuf_valid ? rbuf : data_rsp_rdata;
    assign ld_result    = ld_align(ld_data, alu_p0[OFF_W-1:0], ld_size_p0, ld_uns_p0);

    always_comb begin
        wdata = alu_p0;
        if (ld_req_p0) begin
            wdata = ld_result;
        end else begin
            case (res_sel_p0)
                2'd0:    wdata = alu_p0;
                2'd1:    wdata = mul_result[DATA_W-1:0];
                2'd2:    wdata = mul_result[2*DATA_W-1:DATA_W];
                default: wdata = div_p0;
            endcase
        end
    end

    // EX -> MEM stage register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid   <= 1'b0;
            pc_p0       <= '0;
            rf_we_p0    <= 1'b0;
            rf_waddr_p0 <= '0;
            alu_p0      <= '0;
            ld_req_p0   <= 1'b0;
            ld_size_p0  <= '0;
            ld_uns_p0   <= 1'b0;
            res_sel_p0  <= '0;
            div_p0      <= '0;
            rbuf_valid  <= 1'b0;
            rbuf        <= '0;
            dcnt        <= '0;
            rsp_err     <= 1'b0;
        end else begin
            if (flush)
                mem_valid <= 1'b0;
            else if (mem_allowin)
                mem_valid <= ex_to_mem_valid;

            if (accept) begin
                pc_p0       <= ex_pc;
                rf_we_p0    <= ex_rf_we;
                rf_waddr_p0 <= ex_rf_waddr;
                alu_p0      <= ex_alu_result;
                ld_req_p0   <= ex_ld_req;
                ld_size_p0  <= ex_ld_size;
                ld_uns_p0   <= ex_ld_unsigned;
                res_sel_p0  <= ex_res_sel;
                div_p0      <= ex_div_result;
            end

            if (flush || mem_leave)
                rbuf_valid <= 1'b0;
            else if (rsp_capture)
                rbuf_valid <= 1'b1;

            if (rsp_capture)
                rbuf <= data_rsp_rdata;

            if (dcnt_inc && !dcnt_dec && dcnt != DCNT_MAX)
                dcnt <= dcnt + DCNT_W'(1);
            else if (dcnt_dec && !dcnt_inc)
                dcnt <= dcnt - DCNT_W'(1);

            if (rsp_unexp || dcnt_ovf)
                rsp_err <= 1'b1;
        end
    end

    assign mem_to_wb_valid    = mem_valid & mem_ready_go & ~flush;
    assign mem_to_wb_pc       = pc_p0;
    assign mem_to_wb_rf_we    = rf_we_p0;
    assign mem_to_wb_rf_waddr = rf_waddr_p0;
    assign mem_to_wb_rf_wdata = wdata;

    assign mem_fwd_we         = mem_valid & rf_we_p0;
    assign mem_fwd_waddr      = rf_waddr_p0;
    assign mem_fwd_wdata      = wdata;
    assign mem_fwd_pending    = mem_valid & ld_req_p0 & ~mem_ready_go;

endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised memory-access pipeline stage between EX and WB for the in-order CPU pipeline. It receives load/ALU/mul/div results from EX and tolerates a variable-latency data-memory response channel, stalling the pipeline until load data arrives. It buffers early load responses while WB stalls and drops responses that belong to flushed loads. It also performs width-generic load alignment and extension and drives a forwarding bus with a data-pending flag.

## Interface
- DATA_W, 32: datapath width; legal values 32 or 64.
- DCNT_W, 2: width of the discard counter for responses owed to flushed loads.

- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ex_to_mem_valid  in  1  EX holds a valid instruction.
- mem_allowin  out  1  MEM can accept from EX this cycle.
- ex_pc  in  32  instruction PC.
- ex_rf_we, ex_rf_waddr  in  1, 5  register write enable and address.
- ex_alu_result  in  DATA_W  ALU result, or load address.
- ex_ld_req  in  1  load whose request was accepted by memory in EX; one response is owed.
- ex_ld_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- ex_ld_unsigned  in  1  zero-extend when 1, sign-extend when 0.
- ex_res_sel  in  2  0 = alu, 1 = mul low, 2 = mul high, 3 = div.
- ex_div_result  in  DATA_W  divider result.
- mul_result  in  2*DATA_W  multiplier product for the instruction currently in MEM; held stable by the multiplier while MEM holds it.
- data_rsp_valid, data_rsp_rdata  in  1, DATA_W  in-order read response, single-cycle pulse.
- flush  in  1  kill the instruction in MEM and block acceptance this cycle.
- wb_allowin  in  1  WB can accept.
- mem_to_wb_valid  out  1  result valid toward WB.
- mem_to_wb_pc, mem_to_wb_rf_we, mem_to_wb_rf_waddr, mem_to_wb_rf_wdata  out  32, 1, 5, DATA_W  payload to WB.
- mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata, mem_fwd_pending  out  1, 5, DATA_W, 1  forwarding bus.
- rsp_err  out  1  sticky flag: unexpected response.

## Operation
- Registered state:
  - mem_valid.
  - Payload register, loaded on ex_to_mem_valid & mem_allowin & ~flush.
  - rbuf_valid and rbuf, the response buffer.
  - dcnt, the discard counter.
  - rsp_err.
- take_rsp = data_rsp_valid & (dcnt == 0).
- mem_ready_go = ~ld_req | rbuf_valid | take_rsp.
- mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
- mem_to_wb_valid = mem_valid & mem_ready_go & ~flush.
- Response routing, in priority order:
  - dcnt > 0: response is dropped; dcnt decrements.
  - Load waiting with ~rbuf_valid and not advancing (~wb_allowin): response is captured into rbuf; rbuf_valid sets.
  - Load waiting and wb_allowin: response is used combinationally.
  - Any other response sets rsp_err and is ignored.
- rbuf_valid clears when the owning instruction leaves MEM or is flushed.
- Load data source: rbuf_valid ? rbuf : data_rsp_rdata.
- Load alignment:
  - Offset = alu_result[log2(DATA_W/8)-1:0].
  - Data is shifted right by offset*8.
  - Result is the low 8/16/32/64 bits, sign- or zero-extended to DATA_W.
  - With DATA_W = 32, size 3 is treated as size 2.
  - Misaligned offsets are not checked; the result is the shifted value.
- Write data: load result if ld_req, else by res_sel:
  - alu_result.
  - mul_result[DATA_W-1:0].
  - mul_result[2*DATA_W-1:DATA_W].
  - div_result.
- Flush:
  - mem_valid clears next cycle and no EX instruction is accepted.
  - If the killed instruction is a load with ~rbuf_valid and no take_rsp this cycle, dcnt increments.
  - Increment and decrement in the same cycle leave dcnt unchanged.
  - dcnt saturates at 2^DCNT_W-1; an increment at saturation sets rsp_err.
- Forwarding:
  - mem_fwd_we = mem_valid & rf_we.
  - mem_fwd_wdata is the same value as mem_to_wb_rf_wdata.
  - mem_fwd_pending = mem_valid & ld_req & ~mem_ready_go.

## Timing
- Reset, asynchronous: mem_valid, rbuf_valid, dcnt, rsp_err, and all payload registers go to 0. Outputs then read:
  - mem_allowin = 1.
  - mem_to_wb_valid = 0.
  - mem_to_wb_rf_we = 0, mem_fwd_we = 0, mem_fwd_pending = 0.
  - Data outputs = 0.
- Reset mid-load discards any owed responses; the memory side is reset together with this stage.
- Non-load: enters on edge N and is presented to WB during cycle N; it advances at edge N+1 if wb_allowin.
- Load, zero-wait: a response in the first MEM cycle gives the same behaviour as a non-load.
- Load, k-cycle wait: mem_to_wb_valid rises in the cycle the response arrives.
- Response during a WB stall: data is held in rbuf and presented every cycle until accepted.
- Back-to-back loads with full throughput sustain 1 instruction per cycle.
- Flush and a new response in the same cycle: the response belongs to the killed load, so it is consumed and dropped; dcnt is unchanged.

## Test plan
- Back-to-back: 4 ALU ops with res_sel 0 and wb_allowin = 1 → 4 consecutive mem_to_wb_valid cycles; wdata equals alu_result.
- 3-cycle load: DATA_W = 32, ld.b unsigned, addr 0x1003, rdata 0x80FF_1234 → mem_fwd_pending high for 2 cycles; wdata 0x0000_0080.
- 64-bit signed halfword: DATA_W = 64, ld.h signed, addr offset 6, rdata 0xBEEF_0000_0000_0000 → wdata 0xFFFF_FFFF_FFFF_BEEF.
- Response during stall: response arrives while wb_allowin = 0 for 3 cycles → rbuf captures it, data is delivered when wb_allowin rises, and a following load's response is not confused with it.
- Flushed load: flush a waiting load, accept a new load next cycle, then 2 responses R1, R2 → R1 dropped (dcnt 1 → 0), new load writes R2; rsp_err stays 0.
- Unexpected response and async reset: a response with MEM empty → rsp_err = 1; deasserting resetn mid-wait → all outputs return to reset values immediately.
